// File: rtl/sap2_mem_pkg.sv
// Shared types and constants for the SAP-2 memory access unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: access state encoding, address/data widths, ROM boundary,
// the released-bus value and a ROM address decode helper.
package sap2_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // First writable address; 0000H-07FFH hold the monitor ROM.
    localparam logic [ADDR_W-1:0] ROM_TOP = 16'h0800;

    // Value placed on the memory data pins when the unit is not driving.
    localparam logic [DATA_W-1:0] HIGH_Z = {DATA_W{1'bz}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic in_rom(input logic [ADDR_W-1:0] addr);
        return addr < ROM_TOP;
    endfunction

endpackage

// File: rtl/mem_access_unit_mar_counter.sv
// Memory address register: loadable 16-bit register with optional increment.
// Latency: load/increment visible one cycle after the enabling edge.
// Backpressure: none; load has priority over increment, clear over both.
// Ports: clk, clr_n (sync active-low clear), ld_i/d_i (parallel load),
// inc_i (add one, wraps FFFFH -> 0000H), q_o (current address).
module mar_counter
    import sap2_mem_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              ld_i,
    input  logic [ADDR_W-1:0] d_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] q_o
);

    logic [ADDR_W-1:0] q_q;
    logic [ADDR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = d_i;
        end else if (inc_i) begin
            q_d = q_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_access_unit.sv
// MAR + MDR + single-byte read/write sequencer for the 64K memory, with
// writes into the monitor ROM (below ROM_TOP) suppressed and flagged.
// Latency: request at edge T0 -> done pulse T1..T2 -> idle at T2 (3 cycles per access).
// Backpressure: loads and requests are only accepted in IDLE; while busy they are dropped.
// Ports: CLK, nCLR (sync active-low), w_bus_in, nLM/nLD (active-low loads),
// rd_req/wr_req, mem_addr/mem_data/mem_nCE (memory side), mdr_out, busy, done, wp_fault.
// Option: define MAR_AUTOINC_EN to step MAR by one after every read or write cycle.
module mem_access_unit
    import sap2_mem_pkg::*;
(
    input  logic              CLK,
    input  logic              nCLR,
    input  logic [ADDR_W-1:0] w_bus_in,
    input  logic              nLM,
    input  logic              nLD,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_nCE,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              wp_fault
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              wp_q, wp_d;
    logic [ADDR_W-1:0] mar_q;
    logic              mar_ld;
    logic              mar_inc;
    logic              drv_en;

    mar_counter u_mar (
        .clk   (CLK),
        .clr_n (nCLR),
        .ld_i  (mar_ld),
        .d_i   (w_bus_in),
        .inc_i (mar_inc),
        .q_o   (mar_q)
    );

`ifdef MAR_AUTOINC_EN
    // Step past the byte just accessed, blocked writes included, so block
    // copies can run without reloading MAR.
    assign mar_inc = (state_q == RD) || (state_q == WR);
`else
    assign mar_inc = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mdr_d   = mdr_q;
        mar_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                mar_ld = !nLM;
                if (!nLD) begin
                    mdr_d = w_bus_in[DATA_W-1:0];
                end
                // Read wins a collision; the write request is simply lost.
                if (rd_req) begin
                    state_d = RD;
                end else if (wr_req) begin
                    state_d = WR;
                end
            end
            RD: begin
                mdr_d   = mem_data;
                state_d = DONE;
            end
            WR: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Remember whether the write just attempted hit ROM; MAR may have moved
    // on by the DONE cycle, so the decode cannot be redone there.
    assign wp_d = (state_q == WR) && in_rom(mar_q);

    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            state_q <= IDLE;
            mdr_q   <= '0;
            wp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mdr_q   <= mdr_d;
            wp_q    <= wp_d;
        end
    end

    // Memory strobes are pure state decodes, so a write cycle interrupted by
    // reset still presents nCE=0 at the reset edge and completes.
    assign drv_en   = (state_q == WR) && !in_rom(mar_q);
    assign mem_nCE  = !drv_en;
    assign mem_data = drv_en ? mdr_q : HIGH_Z;
    assign mem_addr = mar_q;
    assign mdr_out  = mdr_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign wp_fault = (state_q == DONE) && wp_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64K byte memory model.
// Each access pushes its expected MDR/wp_fault onto a scoreboard queue,
// popped and compared when the done pulse appears.
module tb_mem_access_unit;

    logic        CLK;
    logic        nCLR;
    logic [15:0] w_bus_in;
    logic        nLM;
    logic        nLD;
    logic        rd_req;
    logic        wr_req;
    logic [15:0] mem_addr;
    wire  [7:0]  mem_data;
    logic        mem_nCE;
    logic [7:0]  mdr_out;
    logic        busy;
    logic        done;
    logic        wp_fault;

    mem_access_unit dut (
        .CLK      (CLK),
        .nCLR     (nCLR),
        .w_bus_in (w_bus_in),
        .nLM      (nLM),
        .nLD      (nLD),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_nCE  (mem_nCE),
        .mdr_out  (mdr_out),
        .busy     (busy),
        .done     (done),
        .wp_fault (wp_fault)
    );

    // Memory model: preset mem[a] = a[7:0]; writes at the edge while nCE=0;
    // drives its output while the unit is busy and not strobing a write.
    logic [7:0] mem [0:65535];

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] <= a[7:0];
        end
    end

    always @(posedge CLK) begin
        if (!mem_nCE) begin
            mem[mem_addr] <= mem_data;
        end
    end

    assign mem_data = (busy && mem_nCE) ? mem[mem_addr] : 8'hzz;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] mdr;
        logic       wp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mar(input logic [15:0] a);
        w_bus_in = a;
        nLM      = 1'b0;
        tick();
        nLM      = 1'b1;
    endtask

    task automatic load_mdr(input logic [7:0] d);
        w_bus_in = {8'h00, d};
        nLD      = 1'b0;
        tick();
        nLD      = 1'b1;
    endtask

    // One access from IDLE; optionally loads MAR at the request edge and
    // optionally pokes loads/requests during the busy cycle.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic ldm, input logic [15:0] addr,
                          input logic exp_nce, input logic [7:0] exp_dat,
                          input logic [7:0] exp_mdr, input logic exp_wp,
                          input logic poke);
        exp_t e;
        int   n;
        e.mdr = exp_mdr;
        e.wp  = exp_wp;
        if (ldm) begin
            w_bus_in = addr;
            nLM      = 1'b0;
        end
        rd_req = rd;
        wr_req = wr;
        sb.push_back(e);
        tick();
        nLM    = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_nce"}, mem_nCE, exp_nce);
        chk({tag, "_done_early"}, done, 1'b0);
        if (!exp_nce) chk({tag, "_wdata"}, mem_data, exp_dat);
        if (poke) begin
            w_bus_in = 16'hBEEF;
            nLM      = 1'b0;
            nLD      = 1'b0;
            rd_req   = 1'b1;
        end
        n = 0;
        while (!done && n < 4) begin
            tick();
            n++;
        end
        nLM    = 1'b1;
        nLD    = 1'b1;
        rd_req = 1'b0;
        chk({tag, "_done_lat"}, n, 1);
        chk({tag, "_done"}, done, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_mdr"}, mdr_out, e.mdr);
            chk({tag, "_wp"}, wp_fault, e.wp);
        end
        tick();
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_done_off"}, done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] inc_addr;
        nCLR     = 1'b0;
        w_bus_in = 16'h0000;
        nLM      = 1'b1;
        nLD      = 1'b1;
        rd_req   = 1'b1;
        wr_req   = 1'b0;

        // 1: reset held two edges with a read request pending
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wp", wp_fault, 1'b0);
        chk("rst_nce", mem_nCE, 1'b1);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_mdr", mdr_out, 8'h00);
        chk("rst_drive", dut.drv_en, 1'b0);
        rd_req = 1'b0;
        nCLR   = 1'b1;
        tick();
        chk("rst_rel_busy", busy, 1'b0);

        // 2: load MAR and read in the same edge
        access("rd3", 1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 8'h00, 8'h03, 1'b0, 1'b0);

        // 3: write then read back
        load_mar(16'h1234);
        load_mdr(8'hA5);
        access("wr1234", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0);
        chk("mem1234", mem[16'h1234], 8'hA5);
        load_mdr(8'h00);
        access("rd1234", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0);

        // 4: write into ROM is blocked
        load_mar(16'h07FF);
        load_mdr(8'h55);
        access("wr07ff", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h55, 1'b1, 1'b0);
        chk("wr07ff_drive", dut.drv_en, 1'b0);
        chk("mem07ff", mem[16'h07FF], 8'hFF);
        access("rd07ff", 1'b1, 1'b0, 1'b1, 16'h07FF, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);

        // lowest writable address is accepted
        load_mar(16'h0800);
        load_mdr(8'h3C);
        access("wr0800", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0);
        chk("mem0800", mem[16'h0800], 8'h3C);

        // 5a: read/write collision -> read only, no second done
        load_mdr(8'hEE);
        access("coll", 1'b1, 1'b1, 1'b1, 16'h0010, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0);
        chk("coll_mem", mem[16'h0010], 8'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("coll_no_done", done, 1'b0);
        end

        // 5b: loads and requests while busy are ignored
        access("poke", 1'b1, 1'b0, 1'b1, 16'h0020, 1'b1, 8'h00, 8'h20, 1'b0, 1'b1);
`ifdef MAR_AUTOINC_EN
        inc_addr = 16'h0021;
`else
        inc_addr = 16'h0020;
`endif
        chk("poke_addr", mem_addr, inc_addr);
        chk("poke_mdr", mdr_out, 8'h20);

        // 5c: reset during an unprotected write: write lands, unit idles
        load_mar(16'h2000);
        load_mdr(8'h77);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("rstwr_nce", mem_nCE, 1'b0);
        nCLR = 1'b0;
        tick();
        nCLR = 1'b1;
        chk("rstwr_mem", mem[16'h2000], 8'h77);
        chk("rstwr_busy", busy, 1'b0);
        chk("rstwr_addr", mem_addr, 16'h0000);
        chk("rstwr_mdr", mdr_out, 8'h00);
        tick();
        chk("rstwr_done", done, 1'b0);

        // 5d: reset during a read discards the capture
        load_mdr(8'h99);
        w_bus_in = 16'h0005;
        nLM      = 1'b0;
        rd_req   = 1'b1;
        tick();
        nLM    = 1'b1;
        rd_req = 1'b0;
        nCLR   = 1'b0;
        tick();
        nCLR = 1'b1;
        chk("rstrd_mdr", mdr_out, 8'h00);
        chk("rstrd_busy", busy, 1'b0);

        // 6: MAR wrap at FFFFH
        access("rdffff", 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
`ifdef MAR_AUTOINC_EN
        inc_addr = 16'h0000;
`else
        inc_addr = 16'hFFFF;
`endif
        chk("wrap_addr", mem_addr, inc_addr);

        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
